// File: rtl/pll_reset_ctrl.sv
// PLL reset/lock sequencer: timed PLL reset pulse, lock wait with timeout and retry, lock qualification.
// Optional lock-loss event counter on loss_cnt_o when PLL_LOCK_LOSS_CNT_EN is defined.
module pll_reset_ctrl #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 27000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRY        = 7
) (
    input  logic       clkin_i,
    input  logic       reset_i,
    input  logic       lock_i,
    input  logic       force_relock_i,
    output logic       pll_reset_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [3:0] retry_cnt_o,
    output logic [2:0] state_o
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt_o
`endif
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int CNT_MAX = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_RST_PULSE  = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE_CHK = 3'd2,
        ST_READY      = 3'd3,
        ST_FAULT      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         retry_q, retry_d;
    logic               pll_reset_q, pll_reset_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;
    logic               sync1_q, lock_s_q;
    logic [7:0]         loss_q, loss_d;

    // Next-state, counter and output decode; outputs follow the next state so they change with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (force_relock_i) begin
            state_d = ST_RST_PULSE;
            cnt_d   = {CNT_W{1'b0}};
            retry_d = 4'd0;
        end else begin
            case (state_q)
                ST_RST_PULSE: begin
                    if (cnt_q == CNT_W'(RST_PULSE_CYC - 1)) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = ST_STABLE_CHK;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                        cnt_d = {CNT_W{1'b0}};
                        if (retry_q == 4'(MAX_RETRY)) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_RST_PULSE;
                            retry_d = retry_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABLE_CHK: begin
                    if (!lock_s_q) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (cnt_q == CNT_W'(LOCK_STABLE_CYC - 1)) begin
                        state_d = ST_READY;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (!lock_s_q) begin
                        state_d = ST_RST_PULSE;
                        cnt_d   = {CNT_W{1'b0}};
                        retry_d = 4'd0;
                        if (loss_q != 8'hFF) begin
                            loss_d = loss_q + 8'd1;
                        end else begin
                            loss_d = loss_q;
                        end
                    end else begin
                        state_d = ST_READY;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_RST_PULSE;
                    cnt_d   = {CNT_W{1'b0}};
                    retry_d = 4'd0;
                end
            endcase
        end
        pll_reset_d = (state_d == ST_RST_PULSE) || (state_d == ST_FAULT);
        ready_d     = (state_d == ST_READY);
        fault_d     = (state_d == ST_FAULT);
    end

    // Lock synchronizer, FSM state, counters and registered outputs.
    always_ff @(posedge clkin_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= ST_RST_PULSE;
            cnt_q       <= {CNT_W{1'b0}};
            retry_q     <= 4'd0;
            loss_q      <= 8'd0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            sync1_q     <= lock_i;
            lock_s_q    <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_reset_q <= pll_reset_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_reset_o = pll_reset_q;
    assign ready_o     = ready_q;
    assign fault_o     = fault_q;
    assign retry_cnt_o = retry_q;
    assign state_o     = state_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
    assign loss_cnt_o = loss_q;
`else
    logic unused_loss_s;
    assign unused_loss_s = ^loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with short timing parameters and hand-computed edge counts.
`timescale 1ps/1ps
module tb_pll_reset_ctrl;

    logic       clkin_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       lock_i = 1'b0;
    logic       force_relock_i = 1'b0;
    logic       pll_reset_o;
    logic       ready_o;
    logic       fault_o;
    logic [3:0] retry_cnt_o;
    logic [2:0] state_o;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    pll_reset_ctrl #(
        .RST_PULSE_CYC   (4),
        .LOCK_TIMEOUT_CYC(20),
        .LOCK_STABLE_CYC (8),
        .MAX_RETRY       (2)
    ) dut (
        .clkin_i       (clkin_i),
        .reset_i       (reset_i),
        .lock_i        (lock_i),
        .force_relock_i(force_relock_i),
        .pll_reset_o   (pll_reset_o),
        .ready_o       (ready_o),
        .fault_o       (fault_o),
        .retry_cnt_o   (retry_cnt_o),
        .state_o       (state_o)
`ifdef PLL_LOCK_LOSS_CNT_EN
        ,
        .loss_cnt_o    (loss_cnt_o)
`endif
    );

    always begin
        #18518 clkin_i = 1'b1;
        #18519 clkin_i = 1'b0;
    end

    initial begin
        #(37037 * 5000);
        $display("FAIL watchdog got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clkin_i);
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic pr,
                              input logic rdy, input logic flt, input logic [3:0] rc);
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".pll_reset"}, 32'(pll_reset_o), 32'(pr));
        check({tag, ".ready"}, 32'(ready_o), 32'(rdy));
        check({tag, ".fault"}, 32'(fault_o), 32'(flt));
        check({tag, ".retry"}, 32'(retry_cnt_o), 32'(rc));
    endtask

    initial begin
        // Reset values
        tick(2);
        check_outs("reset", 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);

        // 1: pulse after release, lock 10 cycles after pulse ends, qualify in 11 edges
        reset_i = 1'b0;
        tick(3);
        check_outs("t1.pulse", 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick(1);
        check_outs("t1.wait", 3'd1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(10);
        lock_i = 1'b1;
        tick(2);
        check("t1.sync_lat", 32'(state_o), 32'd1);
        tick(1);
        check("t1.stable", 32'(state_o), 32'd2);
        tick(7);
        check("t1.ready_early", 32'(ready_o), 32'd0);
        tick(1);
        check_outs("t1.ready", 3'd3, 1'b0, 1'b1, 1'b0, 4'd0);

        // 4: lock loss in READY
        lock_i = 1'b0;
        tick(2);
        check("t4.ready_hold", 32'(ready_o), 32'd1);
        tick(1);
        check_outs("t4.loss", 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
`ifdef PLL_LOCK_LOSS_CNT_EN
        check("t4.loss_cnt", 32'(loss_cnt_o), 32'd1);
`endif
        tick(3);
        check("t4.pulse_end", 32'(pll_reset_o), 32'd1);
        tick(1);
        check_outs("t4.wait", 3'd1, 1'b0, 1'b0, 1'b0, 4'd0);

        // 2: no lock -> retries then FAULT
        for (int r = 1; r <= 2; r++) begin
            tick(19);
            check("t2.wait_hold", 32'(state_o), 32'd1);
            tick(1);
            check_outs("t2.retry", 3'd0, 1'b1, 1'b0, 1'b0, 4'(r));
            tick(3);
            check("t2.pulse", 32'(pll_reset_o), 32'd1);
            tick(1);
            check("t2.pulse_end", 32'(pll_reset_o), 32'd0);
        end
        tick(19);
        check("t2.last_wait", 32'(state_o), 32'd1);
        tick(1);
        check_outs("t2.fault", 3'd4, 1'b1, 1'b0, 1'b1, 4'd2);
        tick(5);
        check_outs("t2.fault_sticky", 3'd4, 1'b1, 1'b0, 1'b1, 4'd2);

        // 5: force relock from FAULT, then normal lock
        force_relock_i = 1'b1;
        tick(1);
        force_relock_i = 1'b0;
        check_outs("t5.force", 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick(3);
        check("t5.pulse", 32'(pll_reset_o), 32'd1);
        tick(1);
        check("t5.wait", 32'(state_o), 32'd1);
        lock_i = 1'b1;
        tick(10);
        check("t5.ready_early", 32'(ready_o), 32'd0);
        tick(1);
        check_outs("t5.ready", 3'd3, 1'b0, 1'b1, 1'b0, 4'd0);

        // 3: lock glitch during STABLE_CHK
        force_relock_i = 1'b1;
        tick(1);
        force_relock_i = 1'b0;
        tick(4);
        check("t3.wait", 32'(state_o), 32'd1);
        tick(1);
        check("t3.stable", 32'(state_o), 32'd2);
        tick(2);
        lock_i = 1'b0;
        tick(2);
        check("t3.stable_hold", 32'(state_o), 32'd2);
        tick(1);
        check_outs("t3.back_wait", 3'd1, 1'b0, 1'b0, 1'b0, 4'd0);
        lock_i = 1'b1;
        tick(2);
        check("t3.still_wait", 32'(state_o), 32'd1);
        tick(1);
        check("t3.restable", 32'(state_o), 32'd2);
        tick(7);
        check("t3.ready_early", 32'(ready_o), 32'd0);
        tick(1);
        check_outs("t3.ready", 3'd3, 1'b0, 1'b1, 1'b0, 4'd0);

        // 6: async reset mid STABLE_CHK
        force_relock_i = 1'b1;
        tick(1);
        force_relock_i = 1'b0;
        tick(5);
        check("t6.stable", 32'(state_o), 32'd2);
        tick(2);
        #5000 reset_i = 1'b1;
        #1;
        check_outs("t6.async", 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
`ifdef PLL_LOCK_LOSS_CNT_EN
        check("t6.loss_cnt", 32'(loss_cnt_o), 32'd0);
`endif
        tick(2);
        reset_i = 1'b0;
        tick(4);
        check("t6.wait", 32'(state_o), 32'd1);
        tick(1);
        check("t6.stable2", 32'(state_o), 32'd2);
        tick(8);
        check_outs("t6.ready", 3'd3, 1'b0, 1'b1, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
